// File: rtl/packed_union_arbiter_pkg.sv
// Shared types for the packed-union arbiter: FSM state encoding, union member
// selectors, and the union word that the two views alias.
package packed_union_arbiter_pkg;

    // Width of the shared union word; the top-level WIDTH parameter must match this.
    localparam int DATA_W = 8;

    // Union member selectors carried on req_view.
    localparam logic VIEW_V1 = 1'b0;
    localparam logic VIEW_V2 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W/2-1:0] hi;
        logic [DATA_W/2-1:0] lo;
    } half_pair_t;

    // v1 and v2 are two names for the same DATA_W bits.
    typedef union packed {
        logic [DATA_W-1:0] v1;
        half_pair_t        v2;
    } word_u;

endpackage

// File: rtl/packed_union_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. It grants only while enabled. On a tie, the
// requester that did not win the previous grant wins.
module rr_arb2
    import packed_union_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // ptr = 1 means requester 1 wins the next tie.
    logic ptr;

    // Grant decode: single requester wins outright, ties resolved by ptr.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer moves only on a grant, toward the requester that lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (grant != 2'b00) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/packed_union_arbiter.sv
// Arbitrates two requesters onto one packed-union register. Each transaction
// runs IDLE (grant) -> ACCESS (register read or write) -> RESP (hold until
// rsp_ready). Writes through v2 change only the low half. Reads through v2
// return the low half, zero-extended.
module packed_union_arbiter
    import packed_union_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_we,
    input  logic [1:0]         req_view,
    input  logic [2*WIDTH-1:0] req_wdata,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_rdata,
    input  logic               rsp_ready,
    output logic               ERROR
);

    state_t           state, state_next;
    logic             arb_en;
    logic [1:0]       grant;
    logic             gid;
    word_u            word_q;
    logic             we_q, view_q, id_q;
    logic [WIDTH-1:0] wdata_q, rdata_q;
    logic [1:0]       prev_valid, prev_ready;
    logic             error_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .req   (req_valid),
        .grant (grant)
    );

    assign gid       = grant[1];
    assign req_ready = grant;
    assign rsp_id    = id_q;
    assign rsp_rdata = rdata_q;
    assign ERROR     = error_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (req_valid != 2'b00) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State decode: grants only in IDLE, and never while reset is asserted.
    always_comb begin
        arb_en    = (state == ST_IDLE) && !rst;
        rsp_valid = (state == ST_RESP);
    end

    // Capture the winner's command in its grant cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            view_q  <= VIEW_V1;
            id_q    <= 1'b0;
            wdata_q <= '0;
        end else if (grant != 2'b00) begin
            we_q    <= req_we[gid];
            view_q  <= req_view[gid];
            id_q    <= gid;
            wdata_q <= req_wdata[gid*WIDTH +: WIDTH];
        end
    end

    // Register access in ACCESS. The response data then holds until the next access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            rdata_q <= '0;
        end else if (state == ST_ACCESS) begin
            if (we_q) begin
                if (view_q == VIEW_V1) word_q.v1    <= wdata_q;
                else                   word_q.v2.lo <= wdata_q[WIDTH/2-1:0];
                rdata_q <= '0;
            end else begin
                rdata_q <= (view_q == VIEW_V1) ? word_q.v1
                                               : {{(WIDTH/2){1'b0}}, word_q.v2.lo};
            end
        end
    end

    // Sticky protocol check: an ungranted requester drops valid, or rsp_ready is high without rsp_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_valid <= 2'b00;
            prev_ready <= 2'b00;
            error_q    <= 1'b0;
        end else begin
            prev_valid <= req_valid;
            prev_ready <= req_ready;
            if (((prev_valid & ~req_valid & ~prev_ready) != 2'b00) ||
                (rsp_ready && !rsp_valid))
                error_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_packed_union_arbiter.sv
// Bench for packed_union_arbiter: directed scenarios plus random transactions
// checked against a transaction-level model of the union register and arbiter.
module tb_packed_union_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = 2'b00;
    logic [1:0]  req_view = 2'b00;
    logic [15:0] req_wdata = 16'h0;
    logic        rsp_valid;
    logic        rsp_id;
    logic [7:0]  rsp_rdata;
    logic        rsp_ready = 1'b0;
    logic        error;

    packed_union_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_view  (req_view),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_ready (rsp_ready),
        .ERROR     (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: register contents, last granted requester, requesters still waiting.
    logic [7:0] model_word = 8'h00;
    int         last_grant = 1;
    logic [1:0] pending = 2'b00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #1;
        check_val("rst_req_ready", 32'(req_ready), 0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 0);
        check_val("rst_rsp_id",    32'(rsp_id), 0);
        check_val("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check_val("rst_error",     32'(error), 0);
        @(posedge clk); #1;
        rst        = 1'b0;
        model_word = 8'h00;
        last_grant = 1;
        pending    = 2'b00;
    endtask

    // One full transaction, starting at posedge+1 with the DUT idle.
    task automatic issue(input logic [1:0] nv, input logic [1:0] we, input logic [1:0] vw,
                         input logic [15:0] wd, input bit keep, input int delay,
                         output logic [7:0] rd);
        logic [1:0] v;
        logic [7:0] d, exp_rd;
        int g, lat;
        v = nv | pending;
        req_valid = v; req_we = we; req_view = vw; req_wdata = wd;
        #1;
        if (v == 2'b11) g = 1 - last_grant;
        else            g = v[1] ? 1 : 0;
        check_val("grant", 32'(req_ready), 32'(2'b01 << g));
        d = wd[g*8 +: 8];
        if (we[g]) begin
            if (vw[g]) model_word[3:0] = d[3:0];
            else       model_word = d;
            exp_rd = 8'h00;
        end else begin
            exp_rd = vw[g] ? {4'h0, model_word[3:0]} : model_word;
        end
        last_grant = g;
        @(posedge clk); #1;
        pending   = keep ? v : (v & ~(2'b01 << g));
        req_valid = pending;
        check_val("ready_pulse", 32'(req_ready), 0);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            check_val("ready_busy", 32'(req_ready), 0);
        end
        check_val("latency",   32'(lat), 2);
        check_val("rsp_valid", 32'(rsp_valid), 1);
        check_val("rsp_id",    32'(rsp_id), 32'(g));
        check_val("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", 32'(rsp_valid), 1);
            check_val("hold_id",    32'(rsp_id), 32'(g));
            check_val("hold_rdata", 32'(rsp_rdata), 32'(exp_rd));
            check_val("hold_ready", 32'(req_ready), 0);
            check_val("hold_error", 32'(error), 0);
        end
        rd = rsp_rdata;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val("error_clear", 32'(error), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        @(posedge clk); #1;
        do_reset();

        // Write 140 through v1, then read it back through v1 and v2.
        issue(2'b01, 2'b01, 2'b00, {8'h00, 8'd140}, 1'b0, 0, rd);
        issue(2'b10, 2'b00, 2'b00, 16'h0000, 1'b0, 0, rd);
        check_val("read_v1_140", 32'(rd), 32'd140);
        issue(2'b10, 2'b00, 2'b10, 16'h0000, 1'b0, 0, rd);
        check_val("read_v2_lo", 32'(rd), 32'h0C);

        // A write through v2 changes only the low half.
        issue(2'b01, 2'b01, 2'b00, {8'h00, 8'hA5}, 1'b0, 0, rd);
        issue(2'b01, 2'b01, 2'b01, {8'h00, 8'h03}, 1'b0, 0, rd);
        issue(2'b01, 2'b00, 2'b00, 16'h0000, 1'b0, 0, rd);
        check_val("read_v1_a3", 32'(rd), 32'hA3);

        // A stalled consumer: the response holds for 5 cycles.
        issue(2'b10, 2'b00, 2'b00, 16'h0000, 1'b0, 5, rd);

        // Random traffic; losers stay pending until they are served.
        for (int k = 0; k < 30; k++) begin
            issue(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom), 16'($urandom),
                  1'b0, $urandom_range(0, 3), rd);
        end

        // Both requesters held valid from reset: grants alternate, starting with 0.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            issue(2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 0, rd);
            check_val("alt_grant", 32'(last_grant), 32'(k % 2));
        end

        // Reset during the ACCESS cycle of a write: nothing is written.
        do_reset();
        req_valid = 2'b01; req_we = 2'b01; req_view = 2'b00; req_wdata = 16'h00FF;
        #1;
        check_val("ff_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        do_reset();
        issue(2'b01, 2'b00, 2'b00, 16'h0000, 1'b0, 0, rd);
        check_val("after_rst_v1", 32'(rd), 0);

        // Requester 1 drops valid while requester 0 is being served.
        do_reset();
        req_valid = 2'b11; req_we = 2'b00; req_view = 2'b00;
        #1;
        check_val("err_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        check_val("err_set", 32'(error), 1);
        check_val("err_rsp_valid", 32'(rsp_valid), 1);
        check_val("err_rsp_id", 32'(rsp_id), 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_val("err_sticky", 32'(error), 1);
        end
        do_reset();
        check_val("err_cleared", 32'(error), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/packed_union_arbiter.md
PACKED_UNION_ARBITER -- requirements
Module: packed_union_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, width of the shared packed-union register; even values only.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-005 SHALL have port: req_ready  output  2  per-requester accept strobe, one-hot or zero.
REQ-006 SHALL have port: req_we  input  2  per-requester write (1) / read (0).
REQ-007 SHALL have port: req_view  input  2  per-requester union member: 0 = v1 (full word), 1 = v2 (struct {hi, lo}, WIDTH/2 each).
REQ-008 SHALL have port: req_wdata  input  2*WIDTH  per-requester write data, requester i at [i*WIDTH +: WIDTH].
REQ-009 SHALL have port: rsp_valid  output  1  response valid.
REQ-010 SHALL have port: rsp_id  output  1  index of the requester owning the response.
REQ-011 SHALL have port: rsp_rdata  output  WIDTH  read data; 0 for writes.
REQ-012 SHALL have port: rsp_ready  input  1  response consumer ready.
REQ-013 SHALL have port: ERROR  output  1  sticky protocol-violation flag.

Function
REQ-014 SHALL hold one WIDTH-bit packed union, members v1 and v2 aliasing the same bits.
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on grant, ACCESS->RESP unconditionally, RESP->IDLE when rsp_ready=1.
REQ-016 SHALL in IDLE grant when any req_valid=1: single requester wins outright; both valid -> requester not granted last wins (round-robin).
REQ-017 SHALL assert req_ready[g] combinationally for exactly the IDLE grant cycle and latch we, view, wdata, id of g in that cycle.
REQ-018 SHALL hold req_ready=0 in ACCESS and RESP; pending requests wait.
REQ-019 SHALL in ACCESS on write view 0 set v1 = wdata; on write view 1 set v2.lo = wdata[WIDTH/2-1:0], v2.hi unchanged.
REQ-020 SHALL in ACCESS on read view 0 capture v1; on read view 1 capture {zeros, v2.lo}.
REQ-021 SHALL assert rsp_valid two cycles after the accept edge, holding rsp_id/rsp_rdata stable until the rsp_ready handshake.
REQ-022 SHALL allow a new grant in the cycle after RESP exits; minimum three cycles per transaction.
REQ-023 SHALL update the round-robin pointer only on grant.
REQ-024 SHALL set ERROR (sticky until reset) when a requester drops req_valid while ungranted and previously valid, or when rsp_ready=1 while rsp_valid=0.

Reset
REQ-025 SHALL on rst force FSM=IDLE, union=0, pointer so requester 0 wins first tie, req_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, ERROR=0.
REQ-026 SHALL on reset mid-transaction discard the transaction with no partial register write.

Structure
REQ-027 SHALL place the packed union typedef, state enum and view constants in package packed_union_arbiter_pkg.
REQ-028 SHALL implement arbitration in sub-module rr_arb2 (2-way round-robin, grant + pointer).

Verification
REQ-029 SHALL cover: req 0 write view 0 wdata 8'd140, then req 1 read view 0 -> rsp_rdata=140, rsp_id=1; read view 1 -> 8'h0C.
REQ-030 SHALL cover: v1=8'hA5, write view 1 wdata 8'h03 -> subsequent v1 read = 8'hA3.
REQ-031 SHALL cover: both req_valid asserted continuously from reset -> grants alternate 0,1,0,1, each req_ready a one-cycle pulse.
REQ-032 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout, ERROR=0.
REQ-033 SHALL cover: rst pulsed during ACCESS of write 8'hFF -> v1 reads 0 afterwards, all outputs at reset values.
REQ-034 SHALL cover: requester 1 deasserts req_valid while requester 0 is served -> ERROR=1 and stays 1 until rst.
